bcd_stopwatch: RTL
==================

# bcd_stopwatch

Parametrised BCD stopwatch/countdown timer: a NUMCELLS-digit decimal counter advanced at TICKHZ from a CLOCKSPEED system clock. It supports run/pause, count-up with wrap, count-down from a preset with sticky done, and lap capture. It drives the seven-segment display path directly with packed BCD and replaces the fixed 10 ms up-counter timer.

## Interface
- CLOCKSPEED, 12000000: system clock frequency in Hz.
- TICKHZ, 100: count rate in Hz. DIV = CLOCKSPEED/TICKHZ, which must be ≥ 2 and an integer.
- NUMCELLS, 4: number of BCD digits, ≥ 1.
- clock  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle strobe. Toggles run/pause.
- clear  in  1  synchronous clear to IDLE with count 0.
- load  in  1  synchronous load of preset, enters IDLE.
- mode  in  1  0 = count up, 1 = count down. Latched on start from IDLE.
- preset  in  4*NUMCELLS  packed BCD load value; digit 0 in [3:0].
- lap  in  1  capture strobe.
- elapsed  out  4*NUMCELLS  registered packed BCD count.
- lap_value  out  4*NUMCELLS  last captured count.
- lap_valid  out  1  one-cycle pulse the cycle after a capture.
- running  out  1  high in RUN.
- done  out  1  sticky; high in DONE.
- wrap  out  1  one-cycle pulse on up-count rollover.

## Operation
- States are IDLE, RUN, PAUSED and DONE.
- Control priority is clear > load > start. The lower-priority strobes are ignored in the same cycle.
- clear (any state): go to IDLE. Set elapsed = 0 and prescaler = 0, and deassert done.
- load (any state): go to IDLE. Set elapsed = preset, with any digit > 9 clamped to 9. Set prescaler = 0 and deassert done.
- IDLE + start:
  - Latch mode and clear the prescaler.
  - If the latched mode = 1 and elapsed = 0, go to DONE.
  - Otherwise go to RUN.
- RUN + start: go to PAUSED. The prescaler holds its value, so resume continues the partial tick.
- PAUSED + start: go to RUN.
- DONE: start is ignored. Only clear, load or rst leave this state.
- Prescaler: in RUN it counts 0..DIV-1. A tick occurs in the cycle where prescaler = DIV-1, and the prescaler then returns to 0. The prescaler is frozen in all other states.
- Up tick:
  - Digit 0 increments. Any digit that would become 10 becomes 0 and carries into the next digit.
  - When all digits are 9, the tick sets elapsed to 0, pulses wrap and stays in RUN.
- Down tick:
  - Digit 0 decrements. Any digit that would go below 0 becomes 9 and borrows from the next digit.
  - When the result is 0, go to DONE and set done.
- Carry/borrow ripples through all NUMCELLS digits in the same cycle. Digits are never outside 0-9.
- A mode change while in RUN or PAUSED has no effect.
- lap (any state): lap_value <= elapsed as registered in that cycle, i.e. before any same-cycle tick update. lap is honoured even when it coincides with clear or load.

## Timing
- Reset (rst low) takes effect immediately, independent of clock:
  - State goes to IDLE.
  - elapsed, lap_value and prescaler go to 0.
  - lap_valid, running, done, wrap and the latched mode go to 0.
- All outputs are registered. Strobes are sampled on the rising edge, and the effect is visible after that edge.
- running rises 1 cycle after start in IDLE. The first tick occurs DIV cycles after the RUN entry edge.
- elapsed changes on the edge that ends the tick cycle.
- done and running update on the same edge as the final down tick.
- wrap is high for exactly the cycle following the rollover edge.
- Tick coincident with a start (pause):
  - The tick is applied.
  - The state becomes PAUSED with prescaler = 0.
- Tick coincident with clear or load: the tick is discarded.
- Total pause time does not count toward the tick period. A tick interval excludes all cycles spent in PAUSED.

## Test plan
All scenarios use CLOCKSPEED=1000, TICKHZ=100 (DIV=10) and NUMCELLS=4 unless stated otherwise.
1. Reset, then start, then run 100 cycles → elapsed = 0x0010 (carry into digit 1); running = 1; wrap never asserted.
2. NUMCELLS=2: start and run 1000 cycles → elapsed = 0x00 and wrap pulses once at the 100th tick; counting continues, reaching 0x01 after 10 more cycles.
3. Pause/resume:
   - Start and run 25 cycles; elapsed = 0x0002.
   - Pause and hold 50 cycles; elapsed stays 0x0002.
   - Resume; elapsed = 0x0003 exactly 5 cycles after the resume edge.
4. Countdown:
   - load preset=0x0012, set mode=1, start.
   - After 120 cycles: elapsed = 0x0000, done = 1, running = 0.
   - A subsequent start leaves these unchanged.
   - A preset of 0x00A3 loads as 0x0093.
5. Priority and lap:
   - At elapsed = 0x0007, assert lap, clear and start together.
   - Required: lap_value = 0x0007 and lap_valid pulses; state is IDLE with elapsed = 0x0000 and running = 0.
6. Async reset:
   - Drop rst mid-RUN between clock edges.
   - Required: elapsed, running and done = 0 before the next edge.
   - After rst is released, no counting occurs without a start.

Source files
------------

// File: rtl/bcd_stopwatch_if.sv
// Control and display bundle for the BCD stopwatch.
// The master side drives the strobes and preset; the slave side (the
// stopwatch) returns the packed BCD count, the lap capture and the status flags.
interface bcd_stopwatch_if #(
    parameter int NUMCELLS = 4
);
    logic                  start;
    logic                  clear;
    logic                  load;
    logic                  mode;
    logic [4*NUMCELLS-1:0] preset;
    logic                  lap;
    logic [4*NUMCELLS-1:0] elapsed;
    logic [4*NUMCELLS-1:0] lap_value;
    logic                  lap_valid;
    logic                  running;
    logic                  done;
    logic                  wrap;

    modport master (
        output start, clear, load, mode, preset, lap,
        input  elapsed, lap_value, lap_valid, running, done, wrap
    );

    modport slave (
        input  start, clear, load, mode, preset, lap,
        output elapsed, lap_value, lap_valid, running, done, wrap
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch / countdown timer with a run/pause prescaler, sticky done and lap capture.
//
// state  | meaning
// IDLE   | stopped; count is cleared, loaded or left from the last run
// RUN    | prescaler advancing; one BCD step per DIV cycles
// PAUSED | prescaler and count frozen; start resumes the partial tick
// DONE   | countdown reached zero; only clear, load or reset leave
module bcd_stopwatch #(
    parameter int CLOCKSPEED = 12000000,
    parameter int TICKHZ     = 100,
    parameter int NUMCELLS   = 4
) (
    input  logic            clock,
    input  logic            rst,
    bcd_stopwatch_if.slave  bus
);
    localparam int DIV = CLOCKSPEED / TICKHZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int W   = 4 * NUMCELLS;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   elapsed_q, elapsed_nx;
    logic [PW-1:0]  presc, presc_nx;
    logic           mode_q, mode_nx;
    logic           wrap_nx;
    logic [W-1:0]   lap_value_q;
    logic           lap_valid_q;
    logic           running_q;
    logic           done_q;
    logic           wrap_q;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUMCELLS; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NUMCELLS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NUMCELLS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Next state, next count and prescaler; clear beats load beats start.
    always_comb begin
        state_nx   = state;
        elapsed_nx = elapsed_q;
        presc_nx   = presc;
        mode_nx    = mode_q;
        wrap_nx    = 1'b0;
        if (bus.clear) begin
            state_nx   = IDLE;
            elapsed_nx = '0;
            presc_nx   = '0;
        end else if (bus.load) begin
            state_nx   = IDLE;
            elapsed_nx = bcd_clamp(bus.preset);
            presc_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_nx  = bus.mode;
                        presc_nx = '0;
                        state_nx = (bus.mode && elapsed_q == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (presc == PMAX) begin
                        presc_nx = '0;
                        if (mode_q) begin
                            elapsed_nx = bcd_dec(elapsed_q);
                            if (elapsed_nx == '0) state_nx = DONE;
                        end else begin
                            elapsed_nx = bcd_inc(elapsed_q);
                            wrap_nx    = (elapsed_nx == '0);
                        end
                    end else if (!bus.start) begin
                        presc_nx = presc + PW'(1);
                    end
                    // A pause on the final down tick still lands in DONE.
                    if (bus.start && state_nx == RUN) state_nx = PAUSED;
                end
                PAUSED: begin
                    if (bus.start) state_nx = RUN;
                end
                default: ;
            endcase
        end
    end

    // State, count, status and lap registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            elapsed_q   <= '0;
            presc       <= '0;
            mode_q      <= 1'b0;
            lap_value_q <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            elapsed_q   <= elapsed_nx;
            presc       <= presc_nx;
            mode_q      <= mode_nx;
            lap_valid_q <= bus.lap;
            if (bus.lap) lap_value_q <= elapsed_q;
            running_q   <= (state_nx == RUN);
            done_q      <= (state_nx == DONE);
            wrap_q      <= wrap_nx;
        end
    end

    assign bus.elapsed   = elapsed_q;
    assign bus.lap_value = lap_value_q;
    assign bus.lap_valid = lap_valid_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.wrap      = wrap_q;
endmodule
